branch_target_arbiter: RTL
==========================

BRANCH_TARGET_ARBITER -- requirements
Module: branch_target_arbiter

Interface
REQ-001 SHALL have parameter ARB_RR, default 1: 1 selects round-robin arbitration; 0 selects fixed priority with branch winning.
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_i, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port br_valid_i, input, 1 bit: branch request valid.
REQ-005 SHALL have port br_ready_o, output, 1 bit: branch request accepted this cycle.
REQ-006 SHALL have port br_pc4_i, input, 32 bits: PC+4 of the branch instruction.
REQ-007 SHALL have port br_imm_i, input, 32 bits: sign-extended branch offset, in words.
REQ-008 SHALL have port jp_valid_i, input, 1 bit: jump request valid.
REQ-009 SHALL have port jp_ready_o, output, 1 bit: jump request accepted this cycle.
REQ-010 SHALL have port jp_pc4_i, input, 32 bits: PC+4 of the jump instruction.
REQ-011 SHALL have port jp_idx_i, input, 26 bits: jump instruction index field.
REQ-012 SHALL have port tgt_valid_o, output, 1 bit: target register holds a result.
REQ-013 SHALL have port tgt_ready_i, input, 1 bit: consumer takes the result this cycle.
REQ-014 SHALL have port tgt_addr_o, output, 32 bits: computed target address.
REQ-015 SHALL have port tgt_src_o, output, 1 bit: result source; 0 = branch, 1 = jump.

Function
REQ-016 SHALL share one shift-left-two path, shifting by 2 with zero fill, between the branch and jump requesters.
REQ-017 SHALL compute branch target = br_pc4_i + {br_imm_i[29:0], 2'b00}, modulo 2^32, with wrap-around and no overflow flag.
REQ-018 SHALL compute jump target = {jp_pc4_i[31:28], jp_idx_i, 2'b00}.
REQ-019 SHALL implement a two-state output FSM: EMPTY (tgt_valid_o=0) and FULL (tgt_valid_o=1).
REQ-020 SHALL define can_accept = EMPTY or (FULL and tgt_ready_i).
REQ-021 SHALL, in round-robin mode with both requesters valid, grant the requester not granted most recently; last-grant pointer updates only on an accepted request.
REQ-022 SHALL, with exactly one requester valid, grant that requester regardless of the pointer.
REQ-023 SHALL drive br_ready_o = can_accept and grant_br, and jp_ready_o = can_accept and grant_jp, combinationally; never both high.
REQ-024 SHALL transfer on valid and ready high together; latency from acceptance to tgt_valid_o is exactly 1 cycle.
REQ-025 SHALL, when FULL and tgt_ready_i is low, hold tgt_addr_o and tgt_src_o stable and deassert both ready outputs.
REQ-026 SHALL, on a drain and accept in the same cycle, remain FULL and load the new result with no bubble.
REQ-027 SHALL, on a drain with no accept, go to EMPTY.
REQ-028 SHALL require requesters to hold valid and data until ready; a valid dropped before ready is ignored with no state change.
REQ-029 SHALL not let tgt_ready_i while EMPTY affect any state.

Reset
REQ-030 SHALL, when rst_i is low, immediately force: state EMPTY, tgt_valid_o 0, tgt_addr_o 0x00000000, tgt_src_o 0, last-grant pointer = jump (so branch wins first).
REQ-031 SHALL, on reset asserted mid-operation, discard any pending result; requests in flight are not acknowledged.
REQ-032 SHALL, while rst_i is low, hold br_ready_o and jp_ready_o at 0.

Structure
REQ-033 SHALL place the FSM state encoding (EMPTY, FULL) and the source encoding (SRC_BR=0, SRC_JP=1) in the shared CPU package.
REQ-034 SHALL instantiate the existing 32-bit shift-left-two module as its one sub-module, fed by a mux of br_imm_i and {6'b0, jp_idx_i}.

Verification
REQ-035 SHALL cover branch: pc4=0x00400004, imm=0xFFFFFFFF, ready=1 -> next cycle tgt_addr_o=0x00400000, src=0.
REQ-036 SHALL cover jump: pc4=0x80000010, idx=0x0000100 -> tgt_addr_o=0x80000400, src=1.
REQ-037 SHALL cover wrap: pc4=0xFFFFFFFC, imm=0x00000001 -> tgt_addr_o=0x00000000.
REQ-038 SHALL cover fairness: both valid for 4 cycles, tgt_ready_i=1 -> grant order B, J, B, J; ready outputs never both high.
REQ-039 SHALL cover backpressure: FULL with tgt_ready_i=0 for 3 cycles -> outputs stable, both ready outputs 0; then ready=1 with a new request pending -> back-to-back results.
REQ-040 SHALL cover reset mid-operation: rst_i low while FULL -> tgt_valid_o=0 immediately; after release the first grant goes to branch.

Source files
------------

// File: rtl/branch_target_arbiter_pkg.sv
// Shared CPU package: FSM/source encodings, result payload and target helpers
// for the branch/jump target arbiter.
package branch_target_arbiter_pkg;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned IDX_W   = 26;
    localparam int unsigned STATE_W = 1;

    localparam logic [STATE_W-1:0] ST_EMPTY = 1'b0;
    localparam logic [STATE_W-1:0] ST_FULL  = 1'b1;

    localparam logic SRC_BR = 1'b0;
    localparam logic SRC_JP = 1'b1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              src;
    } tgt_t;

    // Branch target: PC+4 plus the already word-shifted offset, wrapping mod 2^32.
    function automatic logic [ADDR_W-1:0] calc_br_target(
        input logic [ADDR_W-1:0] pc4,
        input logic [ADDR_W-1:0] shifted
    );
        return ADDR_W'(pc4 + shifted);
    endfunction

    // Jump target: upper nibble of PC+4 above the shifted 26-bit index.
    function automatic logic [ADDR_W-1:0] calc_jp_target(
        input logic [3:0]        pc4_hi,
        input logic [ADDR_W-1:0] shifted
    );
        return {pc4_hi, shifted[27:0]};
    endfunction

endpackage

// File: rtl/branch_target_arbiter_sl2.sv
// 32-bit shift-left-two with zero fill, shared by branch and jump paths.
module branch_target_arbiter_sl2
    import branch_target_arbiter_pkg::*;
(
    input  logic [ADDR_W-1:0] a,
    output logic [ADDR_W-1:0] y_c
);

    logic unused_top_bits;

    assign y_c             = {a[ADDR_W-3:0], 2'b00};
    assign unused_top_bits = ^a[ADDR_W-1:ADDR_W-2];

endmodule

// File: rtl/branch_target_arbiter.sv
// Arbitrates branch and jump target requests onto one shared shifter and a
// single-entry registered result slot with valid/ready handshakes.
module branch_target_arbiter
    import branch_target_arbiter_pkg::*;
#(
    parameter int unsigned ARB_RR = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              br_valid_i,
    output logic              br_ready_o,
    input  logic [ADDR_W-1:0] br_pc4_i,
    input  logic [ADDR_W-1:0] br_imm_i,
    input  logic              jp_valid_i,
    output logic              jp_ready_o,
    input  logic [ADDR_W-1:0] jp_pc4_i,
    input  logic [IDX_W-1:0]  jp_idx_i,
    output logic              tgt_valid_o,
    input  logic              tgt_ready_i,
    output logic [ADDR_W-1:0] tgt_addr_o,
    output logic              tgt_src_o
);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] next_state;
    logic               last_src;
    tgt_t               result;
    tgt_t               next_result;

    logic               grant_br;
    logic               grant_jp;
    logic               can_accept;
    logic               accept;
    logic [ADDR_W-1:0]  sl_in;
    logic [ADDR_W-1:0]  sl_out;
    logic               unused_jp_pc_bits;

    assign unused_jp_pc_bits = ^jp_pc4_i[ADDR_W-5:0];

    // Grant selection: a lone requester always wins; contention uses the mode.
    always_comb begin
        grant_br = 1'b0;
        grant_jp = 1'b0;
        if (br_valid_i && jp_valid_i) begin
            if ((ARB_RR == 0) || (last_src == SRC_JP)) begin
                grant_br = 1'b1;
            end else begin
                grant_jp = 1'b1;
            end
        end else begin
            grant_br = br_valid_i;
            grant_jp = jp_valid_i;
        end
    end

    // Readies are held low while reset is asserted even though state is EMPTY.
    assign can_accept = rst_i && ((state == ST_EMPTY) || tgt_ready_i);
    assign br_ready_o = can_accept && grant_br;
    assign jp_ready_o = can_accept && grant_jp;
    assign accept     = br_ready_o || jp_ready_o;

    assign sl_in = grant_jp ? {{(ADDR_W-IDX_W){1'b0}}, jp_idx_i} : br_imm_i;

    branch_target_arbiter_sl2 u_sl2 (
        .a   (sl_in),
        .y_c (sl_out)
    );

    always_comb begin
        next_result = result;
        if (accept) begin
            if (grant_jp) begin
                next_result.addr = calc_jp_target(jp_pc4_i[ADDR_W-1:ADDR_W-4], sl_out);
                next_result.src  = SRC_JP;
            end else begin
                next_result.addr = calc_br_target(br_pc4_i, sl_out);
                next_result.src  = SRC_BR;
            end
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= ST_EMPTY;
        end else begin
            state <= next_state;
        end
    end

    // Next state: a drain without a new accept empties the slot.
    always_comb begin
        next_state = state;
        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    next_state = ST_FULL;
                end
            end
            ST_FULL: begin
                if (tgt_ready_i && !accept) begin
                    next_state = ST_EMPTY;
                end
            end
            default: next_state = ST_EMPTY;
        endcase
    end

    // Result payload and last-grant pointer move only on an accepted request.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            result   <= '0;
            last_src <= SRC_JP;
        end else begin
            result <= next_result;
            if (accept) begin
                last_src <= grant_jp ? SRC_JP : SRC_BR;
            end
        end
    end

    assign tgt_valid_o = (state == ST_FULL);
    assign tgt_addr_o  = result.addr;
    assign tgt_src_o   = result.src;

endmodule
